// File: rtl/mips32_mc_control.sv
// Multicycle control sequencer for the mips32 datapath.
// Moore FSM sharing one memory port (ready handshake) between fetch and data
// accesses; also counts retired instructions and halts on unsupported opcodes.
module mips32_mc_control (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        pc_write,
    output logic [1:0]  pc_source,
    output logic        ir_write,
    output logic        iord,
    output logic        mem_read,
    output logic        mem_write,
    output logic        reg_write,
    output logic        reg_dst,
    output logic [1:0]  wb_sel,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [2:0]  alu_op,
    output logic        zero_or_sign,
    output logic [1:0]  load_select,
    output logic [1:0]  store_signal,
    output logic        illegal,
    output logic [3:0]  state,
    output logic [31:0] retired
);

    localparam int unsigned OP_W  = 6;
    localparam int unsigned CNT_W = 32;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OP_W-1:0] OP_ORI   = 6'b001101;
    localparam logic [OP_W-1:0] OP_LUI   = 6'b001111;
    localparam logic [OP_W-1:0] OP_LB    = 6'b100000;
    localparam logic [OP_W-1:0] OP_LH    = 6'b100001;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_LBU   = 6'b100100;
    localparam logic [OP_W-1:0] OP_LHU   = 6'b100101;
    localparam logic [OP_W-1:0] OP_SB    = 6'b101000;
    localparam logic [OP_W-1:0] OP_SH    = 6'b101001;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_LOAD_WB  = 4'd4,
        S_MEM_WR   = 4'd5,
        S_R_EXEC   = 4'd6,
        S_R_WB     = 4'd7,
        S_BRANCH   = 4'd8,
        S_JUMP     = 4'd9,
        S_IMM_EXEC = 4'd10,
        S_IMM_WB   = 4'd11,
        S_LUI_WB   = 4'd12,
        S_HALT     = 4'd15
    } state_t;

    state_t           state_q;
    state_t           state_next;
    logic [OP_W-1:0]  op_q;
    logic [OP_W-1:0]  fn_q;
    logic             illegal_q;
    logic [CNT_W-1:0] retired_q;
    logic             retire;

    // funct is held for the datapath's ALU decode; the sequencer itself never branches on it.
    logic unused_fn;
    assign unused_fn = ^fn_q;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_next;
        end
    end

    // Instruction fields, sticky illegal flag and retired-instruction counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            op_q      <= '0;
            fn_q      <= '0;
            illegal_q <= 1'b0;
            retired_q <= '0;
        end else begin
            if (state_q == S_DECODE) begin
                op_q <= opcode;
                fn_q <= funct;
            end
            if (state_next == S_HALT) begin
                illegal_q <= 1'b1;
            end
            if (retire) begin
                retired_q <= retired_q + CNT_W'(1);
            end
        end
    end

    // Next-state and control decode from the current state and latched opcode.
    always_comb begin
        state_next   = state_q;
        retire       = 1'b0;
        pc_write     = 1'b0;
        pc_source    = 2'b00;
        ir_write     = 1'b0;
        iord         = 1'b0;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        reg_write    = 1'b0;
        reg_dst      = 1'b0;
        wb_sel       = 2'b00;
        alu_src_a    = 1'b0;
        alu_src_b    = 2'b00;
        alu_op       = 3'b000;
        zero_or_sign = 1'b0;
        load_select  = 2'b00;
        store_signal = 2'b00;

        case (state_q)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                if (mem_ready) begin
                    ir_write   = 1'b1;
                    pc_write   = 1'b1;
                    state_next = S_DECODE;
                end
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                case (opcode)
                    OP_RTYPE:                          state_next = S_R_EXEC;
                    OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW,
                    OP_SB, OP_SH, OP_SW:               state_next = S_MEM_ADDR;
                    OP_BEQ:                            state_next = S_BRANCH;
                    OP_J:                              state_next = S_JUMP;
                    OP_ADDI, OP_ORI:                   state_next = S_IMM_EXEC;
                    OP_LUI:                            state_next = S_LUI_WB;
                    default:                           state_next = S_HALT;
                endcase
            end
            S_MEM_ADDR: begin
                alu_src_a    = 1'b1;
                alu_src_b    = 2'b10;
                zero_or_sign = 1'b1;
                // Stores are 101xxx, loads 100xxx.
                state_next   = op_q[3] ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
                if (mem_ready) begin
                    state_next = S_LOAD_WB;
                end
            end
            S_LOAD_WB: begin
                reg_write = 1'b1;
                wb_sel    = 2'b01;
                case (op_q)
                    OP_LB, OP_LBU: load_select = 2'b10;
                    OP_LH, OP_LHU: load_select = 2'b01;
                    default:       load_select = 2'b00;
                endcase
                zero_or_sign = (op_q != OP_LBU) && (op_q != OP_LHU);
                retire       = 1'b1;
                state_next   = S_FETCH;
            end
            S_MEM_WR: begin
                mem_write = 1'b1;
                iord      = 1'b1;
                case (op_q)
                    OP_SB:   store_signal = 2'b10;
                    OP_SH:   store_signal = 2'b01;
                    default: store_signal = 2'b00;
                endcase
                if (mem_ready) begin
                    retire     = 1'b1;
                    state_next = S_FETCH;
                end
            end
            S_R_EXEC: begin
                alu_src_a  = 1'b1;
                alu_op     = 3'b010;
                state_next = S_R_WB;
            end
            S_R_WB: begin
                reg_write  = 1'b1;
                reg_dst    = 1'b1;
                retire     = 1'b1;
                state_next = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a  = 1'b1;
                alu_op     = 3'b001;
                pc_source  = 2'b01;
                pc_write   = zero;
                retire     = 1'b1;
                state_next = S_FETCH;
            end
            S_JUMP: begin
                pc_write   = 1'b1;
                pc_source  = 2'b10;
                retire     = 1'b1;
                state_next = S_FETCH;
            end
            S_IMM_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                if (op_q == OP_ORI) begin
                    alu_op = 3'b011;
                end else begin
                    zero_or_sign = 1'b1;
                end
                state_next = S_IMM_WB;
            end
            S_IMM_WB: begin
                reg_write  = 1'b1;
                retire     = 1'b1;
                state_next = S_FETCH;
            end
            S_LUI_WB: begin
                reg_write  = 1'b1;
                wb_sel     = 2'b10;
                retire     = 1'b1;
                state_next = S_FETCH;
            end
            S_HALT: begin
                state_next = S_HALT;
            end
            default: begin
                // Unused encodings are treated like an unsupported instruction.
                state_next = S_HALT;
            end
        endcase

        // No strobe may fire in a cycle whose closing edge is a reset.
        if (reset) begin
            pc_write  = 1'b0;
            ir_write  = 1'b0;
            mem_read  = 1'b0;
            mem_write = 1'b0;
            reg_write = 1'b0;
            retire    = 1'b0;
        end
    end

    assign state   = state_q;
    assign illegal = illegal_q;
    assign retired = retired_q;

endmodule

// File: doc/mips32_mc_control.md
# mips32_mc_control

Multicycle control sequencer for the mips32 datapath. It replaces the single-cycle decode with a Moore state machine, so the instruction and data memories can share one port with a variable-latency ready handshake, and the ALU can also compute PC+4 and branch targets. Each cycle it drives the register-file, memory, ALU-source, PC and load/store-width controls. It also counts retired instructions and halts on an unsupported opcode.

## Interface
- No parameters.
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- opcode  in  6  instruction[31:26] from IR; sampled only in DECODE
- funct  in  6  instruction[5:0] from IR; sampled only in DECODE
- zero  in  1  ALU zero flag
- mem_ready  in  1  shared memory completes the current access this cycle
- pc_write  out  1  load PC
- pc_source  out  2  00 ALU result, 01 ALUOut (branch target), 10 jump address
- ir_write  out  1  load IR from memory read data
- iord  out  1  memory address: 0 PC, 1 ALUOut
- mem_read, mem_write  out  1 each  memory strobes
- reg_write  out  1  register-file write enable
- reg_dst  out  1  write register: 0 rt, 1 rd
- wb_sel  out  2  write data: 00 ALUOut, 01 extended load data, 10 imm<<16 (lui)
- alu_src_a  out  1  0 PC, 1 rs
- alu_src_b  out  2  00 rt, 01 constant 4, 10 extended imm, 11 extended imm<<2
- alu_op  out  3  000 add, 001 sub, 010 decode funct, 011 or
- zero_or_sign  out  1  1 sign-extend, 0 zero-extend (immediate and load data)
- load_select  out  2  00 word, 01 half, 10 byte
- store_signal  out  2  00 word, 01 half, 10 byte
- illegal  out  1  sticky: unsupported opcode seen
- state  out  4  current state code
- retired  out  32  count of completed instructions

## Operation
- State codes: FETCH 0, DECODE 1, MEM_ADDR 2, MEM_RD 3, LOAD_WB 4, MEM_WR 5, R_EXEC 6, R_WB 7, BRANCH 8, JUMP 9, IMM_EXEC 10, IMM_WB 11, LUI_WB 12, HALT 15.
- Outputs are a function of the state and of the opcode/funct registered in DECODE (op_q, fn_q). Any output not listed for a state is 0.
- FETCH
  - Drives mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=000.
  - While mem_ready=0: hold in FETCH, ir_write=0, pc_write=0.
  - When mem_ready=1: ir_write=1, pc_write=1, pc_source=00; next state DECODE.
- DECODE
  - Latches op_q/fn_q. Computes the branch target: alu_src_a=0, alu_src_b=11, alu_op=000.
  - Dispatch on opcode:
    - 000000 → R_EXEC
    - loads 100000/100100/100001/100101/100011 and stores 101000/101001/101011 → MEM_ADDR
    - 000100 beq → BRANCH
    - 000010 j → JUMP
    - 001000 addi, 001101 ori → IMM_EXEC
    - 001111 lui → LUI_WB
    - any other opcode → HALT
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=000, zero_or_sign=1. Next MEM_RD for a load, MEM_WR for a store.
- MEM_RD: mem_read=1, iord=1; hold until mem_ready=1, then go to LOAD_WB.
- LOAD_WB
  - Drives reg_write=1, reg_dst=0, wb_sel=01.
  - load_select: 10 for lb/lbu, 01 for lh/lhu, 00 for lw.
  - zero_or_sign: 1 for lb/lh/lw, 0 for lbu/lhu.
- MEM_WR
  - Drives mem_write=1, iord=1.
  - store_signal: 10 for sb, 01 for sh, 00 for sw.
  - Hold until mem_ready=1.
- R_EXEC: alu_src_a=1, alu_src_b=00, alu_op=010. R_WB: reg_write=1, reg_dst=1, wb_sel=00.
- IMM_EXEC: alu_src_a=1, alu_src_b=10. addi: alu_op=000, zero_or_sign=1. ori: alu_op=011, zero_or_sign=0.
- IMM_WB: reg_write=1, reg_dst=0, wb_sel=00.
- LUI_WB: reg_write=1, reg_dst=0, wb_sel=10.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=001, pc_source=01, pc_write=zero.
- JUMP: pc_write=1, pc_source=10.
- Final states are LOAD_WB, MEM_WR (on its mem_ready=1 cycle), R_WB, IMM_WB, LUI_WB, BRANCH and JUMP. Each one increments retired by 1 (mod 2^32, wraps to 0) and returns to FETCH.
- HALT: sets illegal=1 and holds with every strobe at 0. Only reset leaves HALT.

## Timing
- While reset=1 at a clock edge: state←FETCH, op_q/fn_q←0, illegal←0, retired←0. During the reset cycle every strobe output (pc_write, ir_write, mem_read, mem_write, reg_write) is forced to 0.
- In the first cycle after reset deasserts, the block is in FETCH with mem_read=1.
- Reset asserted mid-instruction, including during a memory wait: the state returns to FETCH at that edge. No write strobe is asserted in the reset cycle, and retired does not increment.
- Cycle counts with zero-wait memory (mem_ready tied 1):
  - lui, beq, j: 3 cycles
  - R-type, addi/ori, stores: 4 cycles
  - loads: 5 cycles
- Each cycle of mem_ready=0 adds 1 cycle to FETCH, MEM_RD or MEM_WR. The strobes and iord stay stable throughout the wait.
- pc_write and ir_write pulse for exactly one cycle per FETCH completion.

## Test plan
- mem_ready=1, opcode=000000 → state sequence 0,1,6,7,0. reg_write=1 only in state 7, with reg_dst=1. retired goes 0→1.
- lbu (100100), mem_ready low for 2 cycles in MEM_RD → sequence 0,1,2,3,3,3,4,0. In LOAD_WB: load_select=10, zero_or_sign=0, wb_sel=01.
- sh (101001) → MEM_WR with store_signal=01, mem_write=1, iord=1. reg_write stays 0 throughout. Total 4 cycles.
- beq with zero=0, then zero=1 → pc_write stays 0 in BRANCH for the first, then pulses to 1 with pc_source=01. Both take 3 cycles and increment retired.
- opcode=111111 → DECODE then HALT. illegal=1 and all strobes 0 for 10 or more cycles. Asserting reset returns state to 0 with illegal=0.
- Assert reset in MEM_WR while mem_ready=0 → the next state is FETCH, mem_write is never 1 in the reset cycle, and retired is unchanged (0).
